mem_arbiter: RTL

Two-port arbiter and sequencer in front of the 31-bit-word `memory` block. It accepts read/write requests from two requesters: port 0, the CPU operand/instruction path, and port 1, the console/loader path. It picks one with round-robin priority and drives `memory`'s one-cycle `read_enable`/`write_enable` strobes. It holds address and write data stable for the whole access, waits for `finish`, and returns read data plus a completion pulse to the owning port. A watchdog frees the bus if `finish` never arrives.

---
 rtl/mem_pkg.sv | 15 +
 rtl/mem_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mem_pkg.sv
// Shared types and widths for the memory arbiter and its users.
// Holds the sequencer state encoding and the memory word/address widths.
// No logic; imported by the arbiter.
package mem_pkg;

  localparam int MEM_ADDR_W = 12;
  localparam int MEM_WORD_W = 31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the word memory.
// Latency: accept at T, strobe at T+1, done at T+4 (timeout: T+3+TIMEOUT).
// Backpressure: one access in flight; requests wait with valid held until accept.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [MEM_ADDR_W-1:0] req0_addr,
  input  logic [MEM_WORD_W-1:0] req0_wdata,
  output logic                  req0_accept,
  output logic                  req0_done,
  output logic                  req0_err,
  output logic [MEM_WORD_W-1:0] req0_rdata,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [MEM_ADDR_W-1:0] req1_addr,
  input  logic [MEM_WORD_W-1:0] req1_wdata,
  output logic                  req1_accept,
  output logic                  req1_done,
  output logic                  req1_err,
  output logic [MEM_WORD_W-1:0] req1_rdata,
  output logic                  mem_read_enable,
  output logic                  mem_write_enable,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [MEM_WORD_W-1:0] mem_write_data,
  input  logic                  mem_finish,
  input  logic [MEM_WORD_W-1:0] mem_read_data
);

  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);

  state_t     state;
  logic       last_grant;
  logic       owner;
  logic       op_write;
  logic [7:0] wd_cnt;

  logic                  take;
  logic                  winner;
  logic                  win_write;
  logic [MEM_ADDR_W-1:0] win_addr;
  logic [MEM_WORD_W-1:0] win_wdata;

  // On a tie the port that did not win last time gets the bus.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return ~last;
    return v1;
  endfunction

  assign winner    = rr_pick(req0_valid, req1_valid, last_grant);
  // Gated by resetn so nothing looks accepted while reset is being applied.
  assign take      = resetn && (state == ST_IDLE) && (req0_valid || req1_valid);
  assign req0_accept = take && !winner;
  assign req1_accept = take && winner;
  assign win_write = winner ? req1_write : req0_write;
  assign win_addr  = winner ? req1_addr  : req0_addr;
  assign win_wdata = winner ? req1_wdata : req0_wdata;

  // Sequencer: grant, one-cycle strobe, wait for finish or watchdog, report.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state            <= ST_IDLE;
      last_grant       <= 1'b1;
      owner            <= 1'b0;
      op_write         <= 1'b0;
      wd_cnt           <= '0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_addr         <= '0;
      mem_write_data   <= '0;
      req0_done        <= 1'b0;
      req0_err         <= 1'b0;
      req0_rdata       <= '0;
      req1_done        <= 1'b0;
      req1_err         <= 1'b0;
      req1_rdata       <= '0;
    end else begin
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      req0_done        <= 1'b0;
      req0_err         <= 1'b0;
      req1_done        <= 1'b0;
      req1_err         <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (take) begin
            owner            <= winner;
            last_grant       <= winner;
            op_write         <= win_write;
            mem_addr         <= win_addr;
            mem_write_data   <= win_wdata;
            // Strobe is registered so it is high exactly during ISSUE.
            mem_write_enable <= win_write;
            mem_read_enable  <= !win_write;
            state            <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wd_cnt <= '0;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_finish) begin
            state <= ST_IDLE;
            if (owner) begin
              req1_done <= 1'b1;
              if (!op_write) req1_rdata <= mem_read_data;
            end else begin
              req0_done <= 1'b1;
              if (!op_write) req0_rdata <= mem_read_data;
            end
          end else if (wd_cnt == WD_LIMIT) begin
            // Memory never answered: free the bus, keep old read data.
            state <= ST_IDLE;
            if (owner) begin
              req1_done <= 1'b1;
              req1_err  <= 1'b1;
            end else begin
              req0_done <= 1'b1;
              req0_err  <= 1'b1;
            end
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
